// File: rtl/output_handling_if.sv
// NPU output-stage bus: FIFO drain side and output image RAM write side.
// The design drives this bus through the master modport; the environment uses the slave modport.
interface output_handling_if #(
  parameter int unsigned AW = 16
) ();
  logic          output_fifo_empty;
  logic [31:0]   output_fifo_data;
  logic          output_fifo_read_enable;
  logic [AW-1:0] output_ram_addr;
  logic [63:0]   output_ram_data;
  logic [7:0]    output_ram_byte_enable;

  modport master (
    input  output_fifo_empty,
    input  output_fifo_data,
    output output_fifo_read_enable,
    output output_ram_addr,
    output output_ram_data,
    output output_ram_byte_enable
  );

  modport slave (
    output output_fifo_empty,
    output output_fifo_data,
    input  output_fifo_read_enable,
    input  output_ram_addr,
    input  output_ram_data,
    input  output_ram_byte_enable
  );
endinterface

// File: rtl/output_handling.sv
// Drains NPU results, clamps them to bytes and packs them into 64-bit output RAM words.
// Optional OUTPUT_ABS_EN: map each result to min(|result|, 255) instead of clamping to [0,255].
module output_handling #(
  parameter int unsigned IMG_W     = 640,
  parameter int unsigned COL_FIRST = 1,
  parameter int unsigned COL_LAST  = 638,
  parameter int unsigned ROW_FIRST = 1,
  parameter int unsigned ROW_LAST  = 478,
  parameter int unsigned AW        = 16
) (
  input  logic                clk,
  input  logic                reset,
  output_handling_if.master   bus,
  output logic                frame_done
);

  localparam int unsigned TOTAL = (ROW_LAST - ROW_FIRST + 1) * (COL_LAST - COL_FIRST + 1);
  localparam int unsigned CNT_W = $clog2(TOTAL + 1);
  localparam int unsigned ROW_W = $clog2(ROW_LAST + 2);
  localparam int unsigned COL_W = $clog2(COL_LAST + 1);
  localparam int unsigned PA_W  = AW + 3;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [CNT_W-1:0]  reads_q, reads_d;
  logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic              pix_valid_q, pix_valid_d;
  logic [63:0]       buf_data_q, buf_data_d;
  logic [7:0]        buf_mask_q, buf_mask_d;
  logic [AW-1:0]     buf_word_q, buf_word_d;
  logic [AW-1:0]     ram_addr_q, ram_addr_d;
  logic [63:0]       ram_data_q, ram_data_d;
  logic [7:0]        ram_be_q, ram_be_d;
  logic              frame_done_q, frame_done_d;

  logic              rd_en_c;
  logic [PA_W-1:0]   pix_addr;
  logic [AW-1:0]     pix_word;
  logic [2:0]        pix_lane;
  logic [7:0]        pix_byte;

  // Linear pixel address of the current (row, col) position.
  always_comb begin
    pix_addr = PA_W'(row_q) * PA_W'(IMG_W) + PA_W'(col_q);
    pix_word = pix_addr[PA_W-1:3];
    pix_lane = pix_addr[2:0];
  end

`ifdef OUTPUT_ABS_EN
  logic [31:0] mag;

  // Magnitude saturated to a byte; -2^31 stays 0x80000000 and therefore saturates.
  always_comb begin
    mag      = bus.output_fifo_data[31] ? 32'(~bus.output_fifo_data + 32'd1)
                                        : bus.output_fifo_data;
    pix_byte = (|mag[31:8]) ? 8'hFF : mag[7:0];
  end
`else
  // Signed clamp to [0,255].
  always_comb begin
    if (bus.output_fifo_data[31]) begin
      pix_byte = 8'h00;
    end else if (|bus.output_fifo_data[30:8]) begin
      pix_byte = 8'hFF;
    end else begin
      pix_byte = bus.output_fifo_data[7:0];
    end
  end
`endif

  // Next-state, position tracking, packing buffer and emit decisions.
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    reads_d      = reads_q;
    pix_cnt_d    = pix_cnt_q;
    buf_data_d   = buf_data_q;
    buf_mask_d   = buf_mask_q;
    buf_word_d   = buf_word_q;
    ram_addr_d   = ram_addr_q;
    ram_data_d   = ram_data_q;
    ram_be_d     = 8'h00;
    frame_done_d = frame_done_q;

    rd_en_c     = (state_q == RUN) && !bus.output_fifo_empty && (reads_q < CNT_W'(TOTAL));
    pix_valid_d = rd_en_c;
    if (rd_en_c) begin
      reads_d = reads_q + CNT_W'(1);
    end

    case (state_q)
      RUN: begin
        if (pix_valid_q) begin
          // A pixel in a different word pushes the old buffer out on this edge.
          if ((buf_mask_q != 8'h00) && (pix_word != buf_word_q)) begin
            ram_addr_d = buf_word_q;
            ram_data_d = buf_data_q;
            ram_be_d   = buf_mask_q;
            buf_data_d = 64'h0;
            buf_mask_d = 8'h00;
          end
          buf_word_d                           = pix_word;
          buf_data_d[{pix_lane, 3'b000} +: 8]  = pix_byte;
          buf_mask_d[pix_lane]                 = 1'b1;

          if (col_q == COL_W'(COL_LAST)) begin
            col_d = COL_W'(COL_FIRST);
            row_d = row_q + ROW_W'(1);
          end else begin
            col_d = col_q + COL_W'(1);
          end

          pix_cnt_d = pix_cnt_q + CNT_W'(1);
          if (pix_cnt_q == CNT_W'(TOTAL - 1)) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (buf_mask_q != 8'h00) begin
          ram_addr_d = buf_word_q;
          ram_data_d = buf_data_q;
          ram_be_d   = buf_mask_q;
        end
        buf_data_d = 64'h0;
        buf_mask_d = 8'h00;
        state_d    = DONE;
      end
      DONE: begin
        frame_done_d = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= RUN;
      row_q        <= ROW_W'(ROW_FIRST);
      col_q        <= COL_W'(COL_FIRST);
      reads_q      <= '0;
      pix_cnt_q    <= '0;
      pix_valid_q  <= 1'b0;
      buf_data_q   <= 64'h0;
      buf_mask_q   <= 8'h00;
      buf_word_q   <= '0;
      ram_addr_q   <= '0;
      ram_data_q   <= 64'h0;
      ram_be_q     <= 8'h00;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      reads_q      <= reads_d;
      pix_cnt_q    <= pix_cnt_d;
      pix_valid_q  <= pix_valid_d;
      buf_data_q   <= buf_data_d;
      buf_mask_q   <= buf_mask_d;
      buf_word_q   <= buf_word_d;
      ram_addr_q   <= ram_addr_d;
      ram_data_q   <= ram_data_d;
      ram_be_q     <= ram_be_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.output_fifo_read_enable = rd_en_c;
  assign bus.output_ram_addr         = ram_addr_q;
  assign bus.output_ram_data         = ram_data_q;
  assign bus.output_ram_byte_enable  = ram_be_q;
  assign frame_done                  = frame_done_q;

endmodule

// File: tb/tb_output_handling.sv
// Bench for output_handling: FIFO model, per-pixel reference packer and write scoreboard.
// Uses a shortened frame (ROW_LAST=8) so a complete frame fits in a short run.
module tb_output_handling;

  localparam int IMG_W     = 640;
  localparam int COL_FIRST = 1;
  localparam int COL_LAST  = 638;
  localparam int ROW_FIRST = 1;
  localparam int ROW_LAST  = 8;
  localparam int AW        = 16;
  localparam int NC        = COL_LAST - COL_FIRST + 1;
  localparam int TOTAL     = (ROW_LAST - ROW_FIRST + 1) * NC;
  localparam int LAST_WORD = (ROW_LAST * IMG_W + COL_LAST) / 8;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  be;
    logic [63:0] data;
  } wr_t;

  logic clk;
  logic reset;
  logic frame_done;

  output_handling_if #(.AW(AW)) bus ();

  output_handling #(
    .IMG_W(IMG_W), .COL_FIRST(COL_FIRST), .COL_LAST(COL_LAST),
    .ROW_FIRST(ROW_FIRST), .ROW_LAST(ROW_LAST), .AW(AW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int   fifo_q[$];
  wr_t  exp_q[$];
  bit   pend;
  int   pend_val;
  int   mode;
  bit   gate;
  int   pops, cyc, writes_seen, last_wr_cyc, fd_cyc;
  logic [15:0] first_addr, last_addr;
  logic [7:0]  first_be, last_be;
  logic [63:0] first_data;
  logic [7:0]  be_by_addr[int];

  int          m_idx;
  logic [15:0] m_word;
  logic [7:0]  m_mask;
  logic [63:0] m_data;

  function automatic logic [7:0] exp_byte(int res);
    longint v;
    v = res;
`ifdef OUTPUT_ABS_EN
    if (v < 0) v = -v;
`endif
    if (v < 0) return 8'h00;
    if (v > 255) return 8'hFF;
    return 8'(v);
  endfunction

  function automatic int rnd_res();
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(0, 255));
      1:       return -int'($urandom_range(1, 1000));
      2:       return int'($urandom_range(256, 100000));
      default: return int'($urandom());
    endcase
  endfunction

  // Reference: place result number m_idx at its interior pixel and group pixels by word.
  task automatic model_push(input int res);
    int r, c, a, ln;
    logic [15:0] wd;
    wr_t w;
    r  = ROW_FIRST + m_idx / NC;
    c  = COL_FIRST + m_idx % NC;
    a  = r * IMG_W + c;
    wd = 16'(a / 8);
    ln = a % 8;
    if (m_mask != 8'h00 && wd != m_word) begin
      w.addr = m_word; w.be = m_mask; w.data = m_data;
      exp_q.push_back(w);
      m_mask = 8'h00;
      m_data = 64'h0;
    end
    m_word = wd;
    m_mask[ln] = 1'b1;
    m_data[ln*8 +: 8] = exp_byte(res);
    m_idx++;
    fifo_q.push_back(res);
  endtask

  task automatic model_flush();
    wr_t w;
    if (m_mask != 8'h00) begin
      w.addr = m_word; w.be = m_mask; w.data = m_data;
      exp_q.push_back(w);
      m_mask = 8'h00;
    end
  endtask

  // One clock: check any write, present popped data, drive empty, then pop on read_enable.
  task automatic step();
    wr_t w;
    @(negedge clk);
    cyc++;
    if (frame_done === 1'b1 && fd_cyc < 0) fd_cyc = cyc;
    if (bus.output_ram_byte_enable !== 8'h00) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%0d be=%h data=%h, expected no write",
                 bus.output_ram_addr, bus.output_ram_byte_enable, bus.output_ram_data);
      end else begin
        w = exp_q.pop_front();
        if (bus.output_ram_addr !== w.addr || bus.output_ram_byte_enable !== w.be ||
            bus.output_ram_data !== w.data) begin
          errors++;
          $display("FAIL write: got addr=%0d be=%h data=%h, expected addr=%0d be=%h data=%h",
                   bus.output_ram_addr, bus.output_ram_byte_enable, bus.output_ram_data,
                   w.addr, w.be, w.data);
        end
      end
      if (writes_seen == 0) begin
        first_addr = bus.output_ram_addr;
        first_be   = bus.output_ram_byte_enable;
        first_data = bus.output_ram_data;
      end
      last_addr   = bus.output_ram_addr;
      last_be     = bus.output_ram_byte_enable;
      last_wr_cyc = cyc;
      be_by_addr[int'(bus.output_ram_addr)] = bus.output_ram_byte_enable;
      writes_seen++;
    end
    bus.output_fifo_data = pend ? pend_val : int'($urandom());
    pend = 1'b0;
    case (mode)
      0:       gate = 1'b0;
      1:       gate = ~gate;
      default: gate = ($urandom_range(0, 3) == 0);
    endcase
    bus.output_fifo_empty = (fifo_q.size() == 0) || gate;
    #1;
    if (bus.output_fifo_read_enable === 1'b1) begin
      checks++;
      if (bus.output_fifo_empty) begin
        errors++;
        $display("FAIL read_while_empty: got read_enable=1, expected 0");
      end else begin
        pend     = 1'b1;
        pend_val = fifo_q.pop_front();
        pops++;
      end
    end
  endtask

  task automatic clear_bench();
    fifo_q.delete();
    exp_q.delete();
    be_by_addr.delete();
    pend = 1'b0; gate = 1'b0;
    pops = 0; writes_seen = 0; fd_cyc = -1; last_wr_cyc = -1;
    m_idx = 0; m_word = '0; m_mask = '0; m_data = '0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    bus.output_fifo_empty = 1'b1;
    bus.output_fifo_data  = '0;
    clear_bench();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((fifo_q.size() != 0 || pend) && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL drain_timeout: got %0d results left after %0d cycles, expected 0",
               fifo_q.size(), n);
    end
    repeat (4) step();
  endtask

  task automatic check_scoreboard_empty(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_writes: got %0d writes outstanding, expected 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.output_fifo_empty = 1'b1;
    bus.output_fifo_data  = '0;
    clear_bench();
    repeat (3) @(negedge clk);
    checks += 5;
    if (bus.output_fifo_read_enable !== 1'b0) begin errors++;
      $display("FAIL reset_read_enable: got %b expected 0", bus.output_fifo_read_enable); end
    if (bus.output_ram_byte_enable !== 8'h00) begin errors++;
      $display("FAIL reset_byte_enable: got %h expected 00", bus.output_ram_byte_enable); end
    if (bus.output_ram_addr !== 16'h0) begin errors++;
      $display("FAIL reset_addr: got %h expected 0000", bus.output_ram_addr); end
    if (bus.output_ram_data !== 64'h0) begin errors++;
      $display("FAIL reset_data: got %h expected 0", bus.output_ram_data); end
    if (frame_done !== 1'b0) begin errors++;
      $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    reset = 1'b0;
  endtask

  task automatic test_pack();
    apply_reset();
    mode = 0;
    for (int k = 10; k <= 16; k++) model_push(k);
    model_push(20);
    drain(200);
    checks += 3;
    if (first_addr !== 16'd80) begin errors++;
      $display("FAIL pack_addr: got %0d expected 80", first_addr); end
    if (first_be !== 8'hFE) begin errors++;
      $display("FAIL pack_be: got %h expected fe", first_be); end
    if (first_data !== 64'h100F0E0D0C0B0A00) begin errors++;
      $display("FAIL pack_data: got %h expected 100f0e0d0c0b0a00", first_data); end
    check_scoreboard_empty("pack");
  endtask

  task automatic test_clamp();
    logic [31:0] exp_lanes;
    apply_reset();
    mode = 0;
    model_push(-5);
    model_push(300);
    model_push(int'(32'h80000000));
    model_push(255);
    for (int k = 1; k <= 5; k++) model_push(k);
`ifdef OUTPUT_ABS_EN
    exp_lanes = 32'hFFFFFF05;
`else
    exp_lanes = 32'hFF00FF00;
`endif
    drain(200);
    checks++;
    if (first_data[39:8] !== exp_lanes) begin errors++;
      $display("FAIL clamp_bytes: got %h expected %h", first_data[39:8], exp_lanes); end
    check_scoreboard_empty("clamp");
  endtask

  task automatic test_toggle();
    apply_reset();
    mode = 1;
    for (int k = 0; k < 64; k++) model_push(rnd_res());
    drain(1000);
    checks++;
    if (pops != 64) begin errors++;
      $display("FAIL toggle_pops: got %0d expected 64", pops); end
    checks++;
    if (writes_seen != 8) begin errors++;
      $display("FAIL toggle_writes: got %0d expected 8", writes_seen); end
    check_scoreboard_empty("toggle");
  endtask

  task automatic test_row_wrap();
    apply_reset();
    mode = 2;
    for (int k = 0; k < 646; k++) model_push(rnd_res());
    drain(4000);
    checks += 2;
    if (!be_by_addr.exists(159)) begin errors++;
      $display("FAIL wrap_word159: got no write expected be=7f");
    end else if (be_by_addr[159] !== 8'h7F) begin errors++;
      $display("FAIL wrap_word159: got be=%h expected 7f", be_by_addr[159]);
    end
    if (!be_by_addr.exists(160)) begin errors++;
      $display("FAIL wrap_word160: got no write expected be=fe");
    end else if (be_by_addr[160] !== 8'hFE) begin errors++;
      $display("FAIL wrap_word160: got be=%h expected fe", be_by_addr[160]);
    end
    check_scoreboard_empty("wrap");
  endtask

  task automatic test_full_frame();
    apply_reset();
    mode = 2;
    for (int k = 0; k < TOTAL; k++) model_push(rnd_res());
    model_flush();
    drain(TOTAL * 4);
    check_scoreboard_empty("frame");
    checks += 3;
    if (last_addr !== 16'(LAST_WORD)) begin errors++;
      $display("FAIL frame_last_addr: got %0d expected %0d", last_addr, LAST_WORD); end
    if (last_be !== 8'h7F) begin errors++;
      $display("FAIL frame_last_be: got %h expected 7f", last_be); end
    if (fd_cyc != last_wr_cyc + 1) begin errors++;
      $display("FAIL frame_done_timing: got cycle %0d expected %0d", fd_cyc, last_wr_cyc + 1); end
    mode = 0;
    for (int k = 0; k < 5; k++) fifo_q.push_back(k);
    for (int k = 0; k < 10; k++) begin
      step();
      checks += 2;
      if (bus.output_fifo_read_enable !== 1'b0) begin errors++;
        $display("FAIL done_read_enable: got %b expected 0", bus.output_fifo_read_enable); end
      if (frame_done !== 1'b1) begin errors++;
        $display("FAIL done_frame_done: got %b expected 1", frame_done); end
    end
  endtask

  task automatic test_midframe_reset();
    apply_reset();
    mode = 0;
    for (int k = 0; k < 200; k++) model_push(rnd_res());
    repeat (60) step();
    #2;
    reset = 1'b1;
    #1;
    checks += 3;
    if (bus.output_ram_byte_enable !== 8'h00) begin errors++;
      $display("FAIL async_reset_be: got %h expected 00", bus.output_ram_byte_enable); end
    if (bus.output_ram_addr !== 16'h0) begin errors++;
      $display("FAIL async_reset_addr: got %h expected 0000", bus.output_ram_addr); end
    if (bus.output_ram_data !== 64'h0) begin errors++;
      $display("FAIL async_reset_data: got %h expected 0", bus.output_ram_data); end
    apply_reset();
    for (int k = 10; k <= 16; k++) model_push(k);
    model_push(20);
    drain(200);
    checks += 2;
    if (first_addr !== 16'd80) begin errors++;
      $display("FAIL restart_addr: got %0d expected 80", first_addr); end
    if (first_be !== 8'hFE) begin errors++;
      $display("FAIL restart_be: got %h expected fe", first_be); end
    check_scoreboard_empty("restart");
  endtask

  initial begin
    cyc  = 0;
    mode = 0;
    test_reset();
    test_pack();
    test_clamp();
    test_toggle();
    test_row_wrap();
    test_full_frame();
    test_midframe_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
